// File: rtl/sd_spi_responder_if.sv
// SPI-mode SD link: the initiator (master) drives clock, data-in and chip select;
// the card (slave) drives the response line.
interface sd_spi_responder_if;
  logic SD_CLK;
  logic SD_MOSI;
  logic SD_CS;
  logic SD_MISO;

  modport master (output SD_CLK, SD_MOSI, SD_CS, input SD_MISO);
  modport slave  (input SD_CLK, SD_MOSI, SD_CS, output SD_MISO);
endinterface

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card target: parses command frames, answers R1/R3/R7 and serves CMD17
// block reads from a byte memory. Define SD_RESP_CRC16_EN to send real data CRC16s.
module sd_spi_responder #(
  parameter int unsigned MEM_AW    = 20,
  parameter int unsigned NCR_BYTES = 1,
  parameter int unsigned NAC_BYTES = 4,
  parameter logic [31:0] OCR_VALUE = 32'hC0FF8000
) (
  input  logic              iCLK,
  input  logic              Reset,
  sd_spi_responder_if.slave spi,
  output logic [MEM_AW-1:0] oMemAddress,
  output logic              oMemRead,
  input  logic [7:0]        iMemData,
  output logic              oIdle,
  output logic              oBusy
);

  // Only the argument bits that CMD8 echoes or CMD17 turns into a block index are kept.
  localparam int unsigned ARG_W = (MEM_AW > 21) ? MEM_AW - 9 : 12;

  typedef enum logic [3:0] {
    ST_WAIT_CMD, ST_RECV_ARG, ST_NCR, ST_SEND_R1, ST_SEND_EXTRA,
    ST_NAC, ST_SEND_TOKEN, ST_SEND_DATA, ST_SEND_CRC
  } state_e;

  logic [1:0]        sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d, cs_sync_q, cs_sync_d;
  logic              sclk_prev_q, sclk_prev_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic              miso_q, miso_d;
  state_e            state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [5:0]        cmd_q, cmd_d;
  logic [ARG_W-1:0]  arg_q, arg_d;
  logic [7:0]        r1_q, r1_d;
  logic [31:0]       extra_q, extra_d;
  logic              idle_q, idle_d, app_q, app_d, rd_ok_q, rd_ok_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              mem_read_q, mem_read_d, fetch_q, fetch_d;
  logic [7:0]        data_q, data_d;

  logic              sclk_s, mosi_s, cs_s, sclk_rise, sclk_fall, byte_done;
  logic [7:0]        rx_byte, next_tx;
  logic              crc_clear, crc_step;
  logic [15:0]       crc_value;

  assign sclk_s    = sclk_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign rx_byte   = {rx_q, mosi_s};

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case tree infers a latch.
    sclk_sync_d = {sclk_sync_q[0], spi.SD_CLK};
    mosi_sync_d = {mosi_sync_q[0], spi.SD_MOSI};
    cs_sync_d   = {cs_sync_q[0], spi.SD_CS};
    sclk_prev_d = sclk_s;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    r1_d        = r1_q;
    extra_d     = extra_q;
    idle_d      = idle_q;
    app_d       = app_q;
    rd_ok_d     = rd_ok_q;
    mem_addr_d  = mem_addr_q;
    mem_read_d  = 1'b0;
    fetch_d     = mem_read_q;
    data_d      = fetch_q ? iMemData : data_q;
    byte_done   = 1'b0;
    next_tx     = 8'hFF;
    crc_clear   = 1'b0;
    crc_step    = 1'b0;

    // Deselect wins over any edge seen in the same cycle.
    if (cs_s) begin
      miso_d    = 1'b1;
      bit_cnt_d = '0;
      tx_d      = 8'hFF;
      cnt_d     = '0;
      state_d   = ST_WAIT_CMD;
    end else begin
      if (sclk_rise) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        byte_done = (bit_cnt_q == 3'd7);
      end
      if (sclk_fall) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b1};
      end
    end

    if (byte_done) begin
      unique case (state_q)
        ST_WAIT_CMD: begin
          if (rx_byte[7:6] == 2'b01) begin
            cmd_d   = rx_byte[5:0];
            cnt_d   = '0;
            state_d = ST_RECV_ARG;
          end
        end
        ST_RECV_ARG: begin
          if (cnt_q == 9'd4) begin
            // CRC byte done: decode with the pre-command idle flag.
            rd_ok_d = 1'b0;
            extra_d = '0;
            app_d   = (cmd_q == 6'd55);
            unique case (cmd_q)
              6'd0:  begin r1_d = 8'h01; idle_d = 1'b1; end
              6'd8:  begin r1_d = {7'b0, idle_q}; extra_d = {20'h0, arg_q[11:0]}; end
              6'd55: r1_d = {7'b0, idle_q};
              6'd41: begin
                if (app_q) begin r1_d = 8'h00; idle_d = 1'b0; end
                else r1_d = {5'b0, 1'b1, 1'b0, idle_q};
              end
              6'd58: begin r1_d = {7'b0, idle_q}; extra_d = OCR_VALUE; end
              6'd17: begin
                if (idle_q) r1_d = 8'h05;
                else begin r1_d = 8'h00; rd_ok_d = 1'b1; end
              end
              default: r1_d = {5'b0, 1'b1, 1'b0, idle_q};
            endcase
            cnt_d = '0;
            if (NCR_BYTES == 0) begin
              state_d = ST_SEND_R1;
              next_tx = r1_d;
            end else begin
              state_d = ST_NCR;
            end
          end else begin
            arg_d = {arg_q[ARG_W-9:0], rx_byte};
            cnt_d = cnt_q + 9'd1;
          end
        end
        ST_NCR: begin
          if (cnt_q == 9'(NCR_BYTES - 1)) begin
            state_d = ST_SEND_R1;
            next_tx = r1_q;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
        ST_SEND_R1: begin
          cnt_d = '0;
          if (cmd_q == 6'd8 || cmd_q == 6'd58) begin
            state_d = ST_SEND_EXTRA;
            next_tx = extra_q[31:24];
            extra_d = {extra_q[23:0], 8'hFF};
          end else if (rd_ok_q) begin
            state_d = ST_NAC;
          end else begin
            state_d = ST_WAIT_CMD;
          end
        end
        ST_SEND_EXTRA: begin
          if (cnt_q == 9'd3) begin
            state_d = ST_WAIT_CMD;
          end else begin
            cnt_d   = cnt_q + 9'd1;
            next_tx = extra_q[31:24];
            extra_d = {extra_q[23:0], 8'hFF};
          end
        end
        ST_NAC: begin
          if (cnt_q == 9'(NAC_BYTES - 1)) begin
            state_d    = ST_SEND_TOKEN;
            next_tx    = 8'hFE;
            mem_read_d = 1'b1;
            mem_addr_d = {arg_q[MEM_AW-10:0], 9'b0};
            crc_clear  = 1'b1;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
        ST_SEND_TOKEN: begin
          state_d    = ST_SEND_DATA;
          cnt_d      = '0;
          next_tx    = data_q;
          crc_step   = 1'b1;
          mem_read_d = 1'b1;
          mem_addr_d = mem_addr_q + MEM_AW'(1);
        end
        ST_SEND_DATA: begin
          if (cnt_q == 9'd511) begin
            state_d = ST_SEND_CRC;
            cnt_d   = '0;
            next_tx = crc_value[15:8];
          end else begin
            cnt_d    = cnt_q + 9'd1;
            next_tx  = data_q;
            crc_step = 1'b1;
            // The fetch runs one byte ahead, so the last load issues no read.
            if (cnt_q < 9'd510) begin
              mem_read_d = 1'b1;
              mem_addr_d = mem_addr_q + MEM_AW'(1);
            end
          end
        end
        ST_SEND_CRC: begin
          if (cnt_q == 9'd0) begin
            cnt_d   = 9'd1;
            next_tx = crc_value[7:0];
          end else begin
            state_d = ST_WAIT_CMD;
          end
        end
        default: state_d = ST_WAIT_CMD;
      endcase
      tx_d = next_tx;
    end
  end

  always_ff @(posedge iCLK) begin
    // NOTE: synchronous reset; all state updates use non-blocking assignments.
    if (Reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '1;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= 8'hFF;
      miso_q      <= 1'b1;
      state_q     <= ST_WAIT_CMD;
      cnt_q       <= '0;
      cmd_q       <= '0;
      arg_q       <= '0;
      r1_q        <= 8'hFF;
      extra_q     <= '0;
      idle_q      <= 1'b1;
      app_q       <= 1'b0;
      rd_ok_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_read_q  <= 1'b0;
      fetch_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      r1_q        <= r1_d;
      extra_q     <= extra_d;
      idle_q      <= idle_d;
      app_q       <= app_d;
      rd_ok_q     <= rd_ok_d;
      mem_addr_q  <= mem_addr_d;
      mem_read_q  <= mem_read_d;
      fetch_q     <= fetch_d;
      data_q      <= data_d;
    end
  end

`ifdef SD_RESP_CRC16_EN
  logic [15:0] crc_q, crc_d;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] r;
    r = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (crc_clear)     crc_d = '0;
    else if (crc_step) crc_d = crc16_byte(crc_q, data_q);
  end

  always_ff @(posedge iCLK) begin
    if (Reset) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign crc_value = crc_q;
`else
  logic unused_crc;
  assign unused_crc = crc_clear ^ crc_step;
  assign crc_value  = 16'hFFFF;
`endif

  assign spi.SD_MISO = miso_q;
  assign oMemAddress = mem_addr_q;
  assign oMemRead    = mem_read_q;
  assign oIdle       = idle_q;
  assign oBusy       = (state_q != ST_WAIT_CMD) && (state_q != ST_RECV_ARG);

endmodule
